// File: rtl/armleocpu_cache_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : armleocpu_cache_arbiter_pkg
// Brief    : Cache command/response encodings and arbiter state type.
// Revision : 1.0 - initial release
// ============================================================================
package armleocpu_cache_arbiter_pkg;

  localparam logic [3:0] CACHE_CMD_NONE              = 4'd0;
  localparam logic [3:0] CACHE_CMD_EXECUTE           = 4'd1;
  localparam logic [3:0] CACHE_CMD_LOAD              = 4'd2;
  localparam logic [3:0] CACHE_CMD_STORE             = 4'd3;
  localparam logic [3:0] CACHE_CMD_FLUSH_ALL         = 4'd4;

  localparam logic [3:0] CACHE_RESPONSE_IDLE         = 4'd0;
  localparam logic [3:0] CACHE_RESPONSE_WAIT         = 4'd1;
  localparam logic [3:0] CACHE_RESPONSE_DONE         = 4'd2;
  localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT  = 4'd3;
  localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT    = 4'd4;
  localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED  = 4'd5;
  localparam logic [3:0] CACHE_RESPONSE_UNKNOWNTYPE  = 4'd6;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY0 = 2'd1,
    ARB_BUSY1 = 2'd2
  } arb_state_t;

  // A terminal response ends the cache transaction and frees the port.
  function automatic logic is_terminal(input logic [3:0] resp);
    return (resp == CACHE_RESPONSE_DONE)        ||
           (resp == CACHE_RESPONSE_ACCESSFAULT) ||
           (resp == CACHE_RESPONSE_MISSALIGNED) ||
           (resp == CACHE_RESPONSE_PAGEFAULT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/armleocpu_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : armleocpu_rr_pick2
// Brief    : Combinational two-way pick, round-robin or fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module armleocpu_rr_pick2 #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic w_tie_idx;

  assign w_tie_idx   = (FIXED_PRIORITY != 0) ? 1'b0 : ~rr_last;
  assign grant_valid = |req;
  assign grant_idx   = (req == 2'b11) ? w_tie_idx : req[1];

endmodule
`default_nettype wire

// File: rtl/armleocpu_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : armleocpu_cache_arbiter
// Brief    : Shares one cache command port between fetch (r0) and memory (r1).
// Revision : 1.0 - initial release
// ============================================================================
module armleocpu_cache_arbiter
  import armleocpu_cache_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [3:0]  r0_cmd,
  input  logic [31:0] r0_address,
  input  logic [2:0]  r0_load_type,
  input  logic [1:0]  r0_store_type,
  input  logic [31:0] r0_store_data,
  output logic [3:0]  r0_response,
  output logic [31:0] r0_load_data,
  output logic        r0_reset_done,

  input  logic [3:0]  r1_cmd,
  input  logic [31:0] r1_address,
  input  logic [2:0]  r1_load_type,
  input  logic [1:0]  r1_store_type,
  input  logic [31:0] r1_store_data,
  output logic [3:0]  r1_response,
  output logic [31:0] r1_load_data,
  output logic        r1_reset_done,

  output logic [3:0]  c_cmd,
  output logic [31:0] c_address,
  output logic [2:0]  c_load_type,
  output logic [1:0]  c_store_type,
  output logic [31:0] c_store_data,
  input  logic [3:0]  c_response,
  input  logic [31:0] c_load_data,
  input  logic        c_reset_done,

  output logic        owner,
  output logic        busy,
  output logic        protocol_error
);

  arb_state_t r_state;
  logic       r_rr_last;
  logic       r_protocol_error;

  logic       w_busy;
  logic       w_owner_idx;
  logic       w_terminal;
  logic       w_lost;
  logic       w_arb_cycle;
  logic       w_enable;
  logic [1:0] w_req;
  logic       w_grant_valid;
  logic       w_grant_idx;
  logic       w_issue;
  logic       w_sel;

  assign w_busy      = (r_state != ARB_IDLE);
  assign w_owner_idx = (r_state == ARB_BUSY1);
  assign w_terminal  = w_busy && is_terminal(c_response);
  assign w_lost      = w_busy && (c_response == CACHE_RESPONSE_IDLE);
  assign w_arb_cycle = !w_busy || w_terminal;
  assign w_enable    = !rst && c_reset_done;
  assign w_req       = {r1_cmd != CACHE_CMD_NONE, r0_cmd != CACHE_CMD_NONE};

  armleocpu_rr_pick2 #(
    .FIXED_PRIORITY (FIXED_PRIORITY)
  ) u_pick (
    .req         (w_req),
    .rr_last     (r_rr_last),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  assign w_issue = w_enable && w_arb_cycle && w_grant_valid;
  // Mux follows the new grant when issuing, otherwise stays on the owner.
  assign w_sel   = w_issue ? w_grant_idx : (w_busy ? w_owner_idx : r_rr_last);

  assign c_cmd        = w_issue ? (w_sel ? r1_cmd : r0_cmd) : CACHE_CMD_NONE;
  assign c_address    = w_sel ? r1_address    : r0_address;
  assign c_load_type  = w_sel ? r1_load_type  : r0_load_type;
  assign c_store_type = w_sel ? r1_store_type : r0_store_type;
  assign c_store_data = w_sel ? r1_store_data : r0_store_data;

  always_comb begin
    r0_response = (r0_cmd != CACHE_CMD_NONE) ? CACHE_RESPONSE_WAIT : CACHE_RESPONSE_IDLE;
    r1_response = (r1_cmd != CACHE_CMD_NONE) ? CACHE_RESPONSE_WAIT : CACHE_RESPONSE_IDLE;
    if (!w_enable) begin
      r0_response = CACHE_RESPONSE_IDLE;
      r1_response = CACHE_RESPONSE_IDLE;
    end else if (w_busy) begin
      if (w_owner_idx) r1_response = c_response;
      else             r0_response = c_response;
    end
  end

  assign r0_load_data  = c_load_data;
  assign r1_load_data  = c_load_data;
  assign r0_reset_done = c_reset_done;
  assign r1_reset_done = c_reset_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ARB_IDLE;
      r_rr_last        <= 1'b1;
      r_protocol_error <= 1'b0;
    end else if (c_reset_done) begin
      if (w_lost) begin
        r_protocol_error <= 1'b1;
        r_state          <= ARB_IDLE;
      end else if (w_arb_cycle) begin
        if (w_grant_valid) begin
          r_state   <= w_grant_idx ? ARB_BUSY1 : ARB_BUSY0;
          r_rr_last <= w_grant_idx;
        end else begin
          r_state   <= ARB_IDLE;
        end
      end
    end
  end

  assign owner          = r_rr_last;
  assign busy           = w_busy;
  assign protocol_error = r_protocol_error;

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_armleocpu_cache_arbiter
// Brief    : Bench for the cache arbiter, round-robin and fixed-priority builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_armleocpu_cache_arbiter;

  localparam logic [3:0] N = 4'd0, E = 4'd1, L = 4'd2;
  localparam logic [3:0] RI = 4'd0, RW = 4'd1, RD = 4'd2, RAF = 4'd3, RPF = 4'd4, RMA = 4'd5, RUT = 4'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, c_reset_done;
  logic [3:0]  cmd [2];
  logic [31:0] addr[2];
  logic [2:0]  lt  [2];
  logic [1:0]  st  [2];
  logic [31:0] sd  [2];
  logic [3:0]  c_response;
  logic [31:0] c_load_data;

  logic [3:0]  o_r0_resp[2], o_r1_resp[2], o_ccmd[2];
  logic [31:0] o_r0_ld[2], o_r1_ld[2], o_caddr[2], o_csd[2];
  logic        o_r0_rd[2], o_r1_rd[2], o_owner[2], o_busy[2], o_perr[2];
  logic [2:0]  o_clt[2];
  logic [1:0]  o_cst[2];

  armleocpu_cache_arbiter #(.FIXED_PRIORITY(0)) u_rr (
    .clk(clk), .rst(rst),
    .r0_cmd(cmd[0]), .r0_address(addr[0]), .r0_load_type(lt[0]), .r0_store_type(st[0]), .r0_store_data(sd[0]),
    .r0_response(o_r0_resp[0]), .r0_load_data(o_r0_ld[0]), .r0_reset_done(o_r0_rd[0]),
    .r1_cmd(cmd[1]), .r1_address(addr[1]), .r1_load_type(lt[1]), .r1_store_type(st[1]), .r1_store_data(sd[1]),
    .r1_response(o_r1_resp[0]), .r1_load_data(o_r1_ld[0]), .r1_reset_done(o_r1_rd[0]),
    .c_cmd(o_ccmd[0]), .c_address(o_caddr[0]), .c_load_type(o_clt[0]), .c_store_type(o_cst[0]),
    .c_store_data(o_csd[0]), .c_response(c_response), .c_load_data(c_load_data), .c_reset_done(c_reset_done),
    .owner(o_owner[0]), .busy(o_busy[0]), .protocol_error(o_perr[0])
  );

  armleocpu_cache_arbiter #(.FIXED_PRIORITY(1)) u_fp (
    .clk(clk), .rst(rst),
    .r0_cmd(cmd[0]), .r0_address(addr[0]), .r0_load_type(lt[0]), .r0_store_type(st[0]), .r0_store_data(sd[0]),
    .r0_response(o_r0_resp[1]), .r0_load_data(o_r0_ld[1]), .r0_reset_done(o_r0_rd[1]),
    .r1_cmd(cmd[1]), .r1_address(addr[1]), .r1_load_type(lt[1]), .r1_store_type(st[1]), .r1_store_data(sd[1]),
    .r1_response(o_r1_resp[1]), .r1_load_data(o_r1_ld[1]), .r1_reset_done(o_r1_rd[1]),
    .c_cmd(o_ccmd[1]), .c_address(o_caddr[1]), .c_load_type(o_clt[1]), .c_store_type(o_cst[1]),
    .c_store_data(o_csd[1]), .c_response(c_response), .c_load_data(c_load_data), .c_reset_done(c_reset_done),
    .owner(o_owner[1]), .busy(o_busy[1]), .protocol_error(o_perr[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference: owner is -1 when no transaction is outstanding.
  int m_owner[2];
  bit m_last [2];
  bit m_err  [2];
  bit p_bz   [2];
  bit p_arb  [2];
  int p_g    [2];

  task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc%0d: got %h want %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic check_dut(input int k);
    logic [3:0] e_resp[2];
    logic [3:0] e_cmd;
    int g, sel;
    bit bz, term, arb;
    bz   = (m_owner[k] >= 0);
    term = bz && (c_response inside {RD, RAF, RPF, RMA});
    arb  = !bz || term;
    g    = -1;
    e_cmd = N;
    sel  = bz ? m_owner[k] : int'(m_last[k]);
    for (int n = 0; n < 2; n++) e_resp[n] = (cmd[n] != N) ? RW : RI;
    if (rst || !c_reset_done) begin
      e_resp[0] = RI;
      e_resp[1] = RI;
    end else begin
      if (bz) e_resp[m_owner[k]] = c_response;
      if (arb) begin
        if (cmd[0] != N && cmd[1] != N) g = (k == 1) ? 0 : 1 - int'(m_last[k]);
        else if (cmd[0] != N)           g = 0;
        else if (cmd[1] != N)           g = 1;
        if (g >= 0) begin
          e_cmd = cmd[g];
          sel   = g;
        end
      end
    end
    p_bz[k] = bz; p_arb[k] = arb; p_g[k] = g;
    cmp("c_cmd",          k, 32'(o_ccmd[k]),    32'(e_cmd));
    cmp("c_address",      k, o_caddr[k],        addr[sel]);
    cmp("c_load_type",    k, 32'(o_clt[k]),     32'(lt[sel]));
    cmp("c_store_type",   k, 32'(o_cst[k]),     32'(st[sel]));
    cmp("c_store_data",   k, o_csd[k],          sd[sel]);
    cmp("r0_response",    k, 32'(o_r0_resp[k]), 32'(e_resp[0]));
    cmp("r1_response",    k, 32'(o_r1_resp[k]), 32'(e_resp[1]));
    cmp("r0_load_data",   k, o_r0_ld[k],        c_load_data);
    cmp("r1_load_data",   k, o_r1_ld[k],        c_load_data);
    cmp("r0_reset_done",  k, 32'(o_r0_rd[k]),   32'(c_reset_done));
    cmp("r1_reset_done",  k, 32'(o_r1_rd[k]),   32'(c_reset_done));
    cmp("busy",           k, 32'(o_busy[k]),    32'(bz));
    cmp("owner",          k, 32'(o_owner[k]),   32'(m_last[k]));
    cmp("protocol_error", k, 32'(o_perr[k]),    32'(m_err[k]));
  endtask

  task automatic model_update(input int k);
    if (rst) begin
      m_owner[k] = -1; m_last[k] = 1'b1; m_err[k] = 1'b0;
    end else if (c_reset_done) begin
      if (p_bz[k] && c_response == RI) begin
        m_err[k] = 1'b1; m_owner[k] = -1;
      end else if (p_arb[k]) begin
        m_owner[k] = p_g[k];
        if (p_g[k] >= 0) m_last[k] = p_g[k][0];
      end
    end
  endtask

  task automatic sample_and_check();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    n_vec++;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update(0);
    model_update(1);
    cyc++;
    #1;
  endtask

  typedef struct {
    bit          rst;
    bit          rd;
    logic [3:0]  c0, c1, cresp;
    logic [31:0] ldata;
    logic [3:0]  e_ccmd;
    logic [31:0] e_addr;
    logic [3:0]  e_r0, e_r1;
    bit          e_busy, e_perr;
  } vec_t;

  vec_t vt[20];
  int   issues[2];
  int   rnd;

  initial begin
    // rst, rd, cmd0, cmd1, cresp, ldata, c_cmd, c_address, r0_resp, r1_resp, busy, perr
    vt[0]  = '{1, 1, E, E, RI,  32'h0,  N, 32'h0,    RI, RI,  0, 0};
    vt[1]  = '{1, 1, E, E, RI,  32'h0,  N, 32'h0,    RI, RI,  0, 0};
    vt[2]  = '{0, 1, E, E, RI,  32'h0,  E, 32'h2000, RW, RW,  0, 0};
    vt[3]  = '{0, 1, N, N, RW,  32'h0,  N, 32'h0,    RW, RI,  1, 0};
    vt[4]  = '{0, 1, N, N, RW,  32'h0,  N, 32'h0,    RW, RI,  1, 0};
    vt[5]  = '{0, 1, N, N, RW,  32'h0,  N, 32'h0,    RW, RI,  1, 0};
    vt[6]  = '{0, 1, N, N, RD,  32'h13, N, 32'h0,    RD, RI,  1, 0};
    vt[7]  = '{0, 1, N, N, RI,  32'h0,  N, 32'h0,    RI, RI,  0, 0};
    vt[8]  = '{0, 1, N, L, RI,  32'h0,  L, 32'h1004, RI, RW,  0, 0};
    vt[9]  = '{0, 1, E, N, RW,  32'h0,  N, 32'h0,    RW, RW,  1, 0};
    vt[10] = '{0, 1, E, N, RAF, 32'h0,  E, 32'h2000, RW, RAF, 1, 0};
    vt[11] = '{0, 1, N, N, RW,  32'h0,  N, 32'h0,    RW, RI,  1, 0};
    vt[12] = '{0, 1, N, N, RI,  32'h0,  N, 32'h0,    RI, RI,  1, 0};
    vt[13] = '{0, 1, N, N, RI,  32'h0,  N, 32'h0,    RI, RI,  0, 1};
    vt[14] = '{0, 1, N, L, RI,  32'h0,  L, 32'h1004, RI, RW,  0, 1};
    vt[15] = '{0, 1, N, N, RW,  32'h0,  N, 32'h0,    RI, RW,  1, 1};
    vt[16] = '{1, 1, N, N, RW,  32'h0,  N, 32'h0,    RI, RI,  1, 1};
    vt[17] = '{0, 1, N, N, RI,  32'h0,  N, 32'h0,    RI, RI,  0, 0};
    vt[18] = '{0, 0, E, N, RI,  32'h0,  N, 32'h0,    RI, RI,  0, 0};
    vt[19] = '{0, 1, E, N, RI,  32'h0,  E, 32'h2000, RW, RI,  0, 0};

    rst = 1'b1; c_reset_done = 1'b1; c_response = RI; c_load_data = '0;
    addr[0] = 32'h2000; addr[1] = 32'h1004;
    for (int n = 0; n < 2; n++) begin
      cmd[n] = E; lt[n] = 3'(n); st[n] = 2'(n); sd[n] = 32'hA0 + 32'(n);
    end
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_last[k] = 1'b1; m_err[k] = 1'b0;
    end
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      rst = vt[i].rst; c_reset_done = vt[i].rd;
      cmd[0] = vt[i].c0; cmd[1] = vt[i].c1;
      c_response = vt[i].cresp; c_load_data = vt[i].ldata;
      sample_and_check();
      cmp("tbl_c_cmd",   0, 32'(o_ccmd[0]),    32'(vt[i].e_ccmd));
      if (vt[i].e_ccmd != N) cmp("tbl_c_address", 0, o_caddr[0], vt[i].e_addr);
      cmp("tbl_r0_resp", 0, 32'(o_r0_resp[0]), 32'(vt[i].e_r0));
      cmp("tbl_r1_resp", 0, 32'(o_r1_resp[0]), 32'(vt[i].e_r1));
      cmp("tbl_busy",    0, 32'(o_busy[0]),    32'(vt[i].e_busy));
      cmp("tbl_perr",    0, 32'(o_perr[0]),    32'(vt[i].e_perr));
      if (vt[i].ldata == 32'h13) cmp("tbl_r0_load_data", 0, o_r0_ld[0], 32'h13);
      advance();
    end

    // Both requesters hold their commands; cache finishes every 2 cycles.
    rst = 1'b1; c_reset_done = 1'b1; cmd[0] = N; cmd[1] = N; c_response = RI;
    sample_and_check(); advance();
    rst = 1'b0; cmd[0] = E; cmd[1] = L;
    issues[0] = 0; issues[1] = 0;
    for (int i = 0; i < 12; i++) begin
      c_response = (i == 0) ? RI : ((i % 2 == 1) ? RW : RD);
      sample_and_check();
      for (int k = 0; k < 2; k++) begin
        if (o_ccmd[k] != N) begin
          cmp("alt_grant", k, o_caddr[k],
              (k == 0 && issues[k] % 2 == 1) ? 32'h1004 : 32'h2000);
          issues[k]++;
        end
      end
      advance();
    end
    cmp("alt_issue_count", 0, 32'(issues[0]), 32'd6);
    cmp("alt_issue_count", 1, 32'(issues[1]), 32'd6);

    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      c_reset_done = ($urandom_range(0, 15) != 0);
      for (int n = 0; n < 2; n++) begin
        cmd[n]  = ($urandom_range(0, 2) == 0) ? N : 4'($urandom_range(1, 4));
        addr[n] = $urandom; lt[n] = 3'($urandom); st[n] = 2'($urandom); sd[n] = $urandom;
      end
      rnd = $urandom_range(0, 15);
      case (rnd)
        0:       c_response = RI;
        9, 10:   c_response = RD;
        11:      c_response = RAF;
        12:      c_response = RPF;
        13:      c_response = RMA;
        14:      c_response = RUT;
        default: c_response = RW;
      endcase
      c_load_data = $urandom;
      sample_and_check();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/armleocpu_cache_arbiter.md
Name: armleocpu_cache_arbiter

Overview:
- Shares one armleocpu cache command port between two requesters: r0 is fetch (instruction side) and r1 is the load/store/debug memory unit.
- Locks the grant from command acceptance until the cache's terminal response, so each multi-cycle cache transaction belongs to exactly one owner.
- Routes responses and load data back to that owner and arbitrates simultaneous requests by round-robin or fixed priority.
- Sits between fetch/memory units and the cache, and uses the existing CACHE_CMD_* / CACHE_RESPONSE_* encodings unchanged.

Parameters:
- FIXED_PRIORITY, 0: 0 selects round-robin; 1 means r0 always wins a tie.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rN_cmd  in  4  requester N command (N=0,1); CACHE_CMD_NONE means no request.
- rN_address  in  32  requester N address.
- rN_load_type  in  3  requester N load type (ld_type encoding).
- rN_store_type  in  2  requester N store type.
- rN_store_data  in  32  requester N store data.
- rN_response  out  4  response to requester N.
- rN_load_data  out  32  load data to requester N; broadcast copy of c_load_data.
- rN_reset_done  out  1  copy of c_reset_done.
- c_cmd  out  4  cache command.
- c_address  out  32  muxed address.
- c_load_type  out  3  muxed load type.
- c_store_type  out  2  muxed store type.
- c_store_data  out  32  muxed store data.
- c_response  in  4  cache response.
- c_load_data  in  32  cache load data.
- c_reset_done  in  1  cache reset complete.
- owner  out  1  current or last grant, for debug.
- busy  out  1  a transaction is outstanding.
- protocol_error  out  1  sticky; cleared only by rst.

Behaviour:
- States: IDLE, BUSY0, BUSY1. Registers: state, rr_last (last granted requester), protocol_error.
- Reset (sync, rst=1):
  - state=IDLE, rr_last=1 so r0 wins the first tie, protocol_error=0.
  - Combinational outputs during reset: c_cmd=NONE, rN_response=IDLE.
  - Reset mid-transaction drops the outstanding transaction; the cache shares rst.
- c_reset_done=0: no grant is made; c_cmd=NONE; both rN_response=IDLE; state holds.
- Arbitration cycle = IDLE state, or a BUSY state whose c_response is terminal (DONE, ACCESSFAULT, MISSALIGNED or PAGEFAULT).
  - Candidates are requesters with rN_cmd!=NONE.
  - One candidate: it is granted.
  - Two candidates: FIXED_PRIORITY=1 grants r0; otherwise grant !rr_last.
  - Granted requester's cmd, address, types and data drive the c_* outputs combinationally in the same cycle (zero-latency issue).
  - Next state = BUSYg; rr_last=g.
  - No candidate: c_cmd=NONE and next state = IDLE.
- Terminal cycle in BUSYx:
  - rx_response = c_response for exactly that cycle.
  - Back-to-back issue in the same cycle is allowed; x's new command competes under the round-robin rule.
- Non-terminal cycle in BUSYx:
  - c_cmd=NONE. The c_address/type/data mux stays on x.
  - rx_response = c_response (WAIT).
- Losing or blocked requester with cmd!=NONE sees rN_response=WAIT and must hold its command until granted. With cmd=NONE it sees IDLE.
- Requester not involved in the current transaction never sees DONE or an error response.
- c_response=IDLE while BUSY:
  - Set protocol_error.
  - Forward IDLE to the owner.
  - Return to IDLE.
- busy=1 in BUSY0/BUSY1. owner = rr_last.
- Widths pass straight through; no arithmetic.
- Estimated size 150-250 lines.

Decomposition:
- CACHE_CMD_* / CACHE_RESPONSE_* stay in armleocpu_cache.vh; load types stay in ld_type.vh.
- New armleocpu_cache_arbiter.vh holds the state encodings (IDLE=0, BUSY0=1, BUSY1=2) and a terminal-response test macro.
- One sub-module: armleocpu_rr_pick2 — combinational 2-way pick from (req[1:0], rr_last, FIXED_PRIORITY) to (grant_valid, grant_idx).

Test Plan:
1. rst=1 for 2 cycles with both rN_cmd=EXECUTE -> c_cmd=NONE, both responses IDLE. After release with c_reset_done=1, r0 is granted first: c_cmd=EXECUTE, c_address=r0_address (0x2000).
2. r0 EXECUTE @0x2000; cache gives WAIT x3 then DONE with load_data 0x00000013 -> r0 sees WAIT x3 then DONE with r0_load_data=0x13; r1 sees IDLE throughout; busy falls after DONE.
3. Both hold LOAD/EXECUTE continuously, cache gives DONE after 2 cycles each -> grants alternate r0,r1,r0,r1; with FIXED_PRIORITY=1 only r0 is served.
4. r1 LOAD @0x1004 returns ACCESSFAULT while r0 waits with EXECUTE -> r1 gets ACCESSFAULT; r0 gets WAIT until the same cycle, then c_cmd=EXECUTE from r0.
5. Inject c_response=IDLE during BUSY0 -> protocol_error=1, state IDLE; protocol_error stays 1 until rst.
6. Assert rst during BUSY1 with WAIT -> next cycle state IDLE, c_cmd=NONE, r1_response=IDLE.
